inst_fetch: RTL and testbench

//   Front end of the Tomasulo core: holds the fetch PC, issues one word read at a time to the memory

---
 rtl/inst_fetch_pkg.sv | 42 ++++
 rtl/inst_fetch_bht.sv | 42 ++++
 rtl/inst_fetch.sv | 180 ++++++++++++++++++
 tb/tb_inst_fetch.sv | 414 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/inst_fetch_pkg.sv
`default_nettype none
// ============================================================================
// | inst_fetch_pkg                                                           |
// | Shared types, RV32 opcode constants and immediate helpers for fetch.     |
// | Revision: 1.0                                                            |
// ============================================================================
package inst_fetch_pkg;

   typedef logic [31:0] ADDR_TYPE;
   typedef logic [31:0] DATA_TYPE;

   localparam logic TRUE  = 1'b1;
   localparam logic FALSE = 1'b0;

   localparam logic [6:0] OPCODE_JAL    = 7'b1101111;
   localparam logic [6:0] OPCODE_JALR   = 7'b1100111;
   localparam logic [6:0] OPCODE_BRANCH = 7'b1100011;

   localparam logic [1:0] BHT_INIT = 2'b01;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_WAIT  = 2'd1,
      ST_DRAIN = 2'd2
   } fetch_state_e;

   typedef struct packed {
      ADDR_TYPE pc;
      DATA_TYPE inst;
      logic     pred_jump;
   } iq_entry_t;

   function automatic ADDR_TYPE imm_j(input DATA_TYPE inst);
      return {{12{inst[31]}}, inst[19:12], inst[20], inst[30:21], 1'b0};
   endfunction

   function automatic ADDR_TYPE imm_b(input DATA_TYPE inst);
      return {{20{inst[31]}}, inst[7], inst[30:25], inst[11:8], 1'b0};
   endfunction

endpackage
`default_nettype wire

// File: rtl/inst_fetch_bht.sv
`default_nettype none
// ============================================================================
// | inst_fetch_bht                                                           |
// | Table of 2-bit saturating direction counters; one read, one update port. |
// | Revision: 1.0                                                            |
// ============================================================================
module inst_fetch_bht
   import inst_fetch_pkg::*;
#(
   parameter int ENTRIES = 256,
   parameter int IDX_W   = $clog2(ENTRIES)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [IDX_W-1:0] rd_idx_i,
   output logic             rd_taken_o,
   input  logic             upd_en_i,
   input  logic [IDX_W-1:0] upd_idx_i,
   input  logic             upd_taken_i
);

   logic [1:0] ctr_q [ENTRIES];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int k = 0; k < ENTRIES; k++) begin
            ctr_q[k] <= BHT_INIT;
         end
      end else if (upd_en_i) begin
         if (upd_taken_i) begin
            if (ctr_q[upd_idx_i] != 2'b11) ctr_q[upd_idx_i] <= ctr_q[upd_idx_i] + 2'd1;
         end else begin
            if (ctr_q[upd_idx_i] != 2'b00) ctr_q[upd_idx_i] <= ctr_q[upd_idx_i] - 2'd1;
         end
      end
   end

   // Read is from the registered table, so a same-cycle update is not visible yet.
   assign rd_taken_o = ctr_q[rd_idx_i][1];

endmodule
`default_nettype wire

// File: rtl/inst_fetch.sv
`default_nettype none
// ============================================================================
// | inst_fetch                                                               |
// | Fetch PC, single-outstanding word read, JAL/B-type next-PC prediction    |
// | and instruction queue. Optional predictor macro: BRANCH_PRED_EN.         |
// | Revision: 1.0                                                            |
// ============================================================================
module inst_fetch
   import inst_fetch_pkg::*;
#(
   parameter int       IQ_DEPTH    = 16,
   parameter int       BHT_ENTRIES = 256,
   parameter ADDR_TYPE RESET_PC    = 32'h0
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        rdy,
   output logic        if_to_mc_enable,
   output logic [31:0] if_to_mc_pc,
   input  logic        mc_to_if_done,
   input  logic [31:0] mc_to_if_inst,
   output logic        if_to_dc_valid,
   output logic [31:0] if_to_dc_inst,
   output logic [31:0] if_to_dc_pc,
   output logic        if_to_dc_pred_jump,
   input  logic        dc_to_if_stall,
   input  logic        clr,
   input  logic        rob_to_if_set_pc_enable,
   input  logic [31:0] rob_to_if_target_pc,
   input  logic        rob_to_if_br_commit_enable,
   input  logic        rob_to_if_br_real_jump,
   input  logic [31:0] rob_to_if_br_pc
);

   localparam int             PTR_W     = $clog2(IQ_DEPTH);
   localparam int             BHT_IDX_W = $clog2(BHT_ENTRIES);
   localparam logic [PTR_W:0] PTR_ONE   = {{PTR_W{1'b0}}, 1'b1};

   fetch_state_e   state_q, state_d;
   ADDR_TYPE       pc_q, pc_d;
   logic           mc_en_q, mc_en_d;
   ADDR_TYPE       mc_pc_q, mc_pc_d;
   logic [PTR_W:0] rd_ptr_q, rd_ptr_d;
   logic [PTR_W:0] wr_ptr_q, wr_ptr_d;
   iq_entry_t      iq_mem_q [IQ_DEPTH];

   logic                 w_full, w_empty, w_push, w_pop;
   logic                 w_bht_taken;
   logic [BHT_IDX_W-1:0] w_bht_rd_idx;
   ADDR_TYPE             w_next_pc;
   logic                 w_pred;
   iq_entry_t            w_push_entry;
   iq_entry_t            w_head;
   logic                 unused_inputs;

   assign w_empty = (rd_ptr_q == wr_ptr_q);
   assign w_full  = (rd_ptr_q[PTR_W] != wr_ptr_q[PTR_W]) &&
                    (rd_ptr_q[PTR_W-1:0] == wr_ptr_q[PTR_W-1:0]);

   assign w_bht_rd_idx = pc_q[BHT_IDX_W+1:2];

`ifdef BRANCH_PRED_EN
   inst_fetch_bht #(
      .ENTRIES (BHT_ENTRIES)
   ) u_bht (
      .clk         (clk),
      .rst_n       (rst_n),
      .rd_idx_i    (w_bht_rd_idx),
      .rd_taken_o  (w_bht_taken),
      .upd_en_i    (rdy & rob_to_if_br_commit_enable),
      .upd_idx_i   (rob_to_if_br_pc[BHT_IDX_W+1:2]),
      .upd_taken_i (rob_to_if_br_real_jump)
   );
   assign unused_inputs = ^{rob_to_if_br_pc[31:BHT_IDX_W+2], rob_to_if_br_pc[1:0]};
`else
   assign w_bht_taken   = FALSE;
   assign unused_inputs = ^{rob_to_if_br_commit_enable, rob_to_if_br_real_jump,
                            rob_to_if_br_pc, w_bht_rd_idx};
`endif

   // Pre-decode of the returning word; pc_q is still the address of that word.
   always_comb begin
      w_next_pc = pc_q + 32'd4;
      w_pred    = FALSE;
      case (mc_to_if_inst[6:0])
         OPCODE_JAL: begin
            w_next_pc = pc_q + imm_j(mc_to_if_inst);
            w_pred    = TRUE;
         end
         OPCODE_BRANCH: begin
            if (w_bht_taken) begin
               w_next_pc = pc_q + imm_b(mc_to_if_inst);
               w_pred    = TRUE;
            end
         end
         OPCODE_JALR: w_pred = FALSE;
         default:     w_pred = FALSE;
      endcase
   end

   assign w_push_entry = '{pc: pc_q, inst: mc_to_if_inst, pred_jump: w_pred};

   always_comb begin
      state_d  = state_q;
      pc_d     = pc_q;
      mc_en_d  = mc_en_q;
      mc_pc_d  = mc_pc_q;
      rd_ptr_d = rd_ptr_q;
      wr_ptr_d = wr_ptr_q;
      w_push   = FALSE;
      w_pop    = FALSE;
      if (clr) begin
         mc_en_d  = FALSE;
         rd_ptr_d = wr_ptr_q;
         if (rob_to_if_set_pc_enable) pc_d = rob_to_if_target_pc;
         // A request still in flight must be drained; one completing now is simply dropped.
         case (state_q)
            ST_WAIT, ST_DRAIN: state_d = mc_to_if_done ? ST_IDLE : ST_DRAIN;
            default:           state_d = ST_IDLE;
         endcase
      end else begin
         w_pop = !w_empty && !dc_to_if_stall;
         case (state_q)
            ST_IDLE: begin
               if (!w_full) begin
                  mc_en_d = TRUE;
                  mc_pc_d = pc_q;
                  state_d = ST_WAIT;
               end
            end
            ST_WAIT: begin
               if (mc_to_if_done) begin
                  w_push  = TRUE;
                  pc_d    = w_next_pc;
                  mc_en_d = FALSE;
                  state_d = ST_IDLE;
               end
            end
            ST_DRAIN: begin
               if (mc_to_if_done) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
         endcase
         if (w_pop)  rd_ptr_d = rd_ptr_q + PTR_ONE;
         if (w_push) wr_ptr_d = wr_ptr_q + PTR_ONE;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= ST_IDLE;
         pc_q     <= RESET_PC;
         mc_en_q  <= FALSE;
         mc_pc_q  <= '0;
         rd_ptr_q <= '0;
         wr_ptr_q <= '0;
      end else if (rdy) begin
         state_q  <= state_d;
         pc_q     <= pc_d;
         mc_en_q  <= mc_en_d;
         mc_pc_q  <= mc_pc_d;
         rd_ptr_q <= rd_ptr_d;
         wr_ptr_q <= wr_ptr_d;
      end
   end

   always_ff @(posedge clk) begin
      if (rdy && w_push) iq_mem_q[wr_ptr_q[PTR_W-1:0]] <= w_push_entry;
   end

   assign w_head             = iq_mem_q[rd_ptr_q[PTR_W-1:0]];
   assign if_to_mc_enable    = mc_en_q;
   assign if_to_mc_pc        = mc_pc_q;
   assign if_to_dc_valid     = !w_empty;
   assign if_to_dc_inst      = w_head.inst;
   assign if_to_dc_pc        = w_head.pc;
   assign if_to_dc_pred_jump = w_head.pred_jump;

endmodule
`default_nettype wire

// File: tb/tb_inst_fetch.sv
`default_nettype none
// ============================================================================
// | tb_inst_fetch                                                            |
// | Randomised and directed bench for inst_fetch with a queue-based model.   |
// | Revision: 1.0                                                            |
// ============================================================================
module tb_inst_fetch;

   localparam int DEPTH = 16;
   localparam int NBHT  = 256;
`ifdef BRANCH_PRED_EN
   localparam bit PRED_EN = 1'b1;
`else
   localparam bit PRED_EN = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        rdy = 1'b1;
   logic        if_to_mc_enable;
   logic [31:0] if_to_mc_pc;
   logic        mc_to_if_done = 1'b0;
   logic [31:0] mc_to_if_inst = 32'h0;
   logic        if_to_dc_valid;
   logic [31:0] if_to_dc_inst;
   logic [31:0] if_to_dc_pc;
   logic        if_to_dc_pred_jump;
   logic        dc_to_if_stall = 1'b1;
   logic        clr = 1'b0;
   logic        set_pc_en = 1'b0;
   logic [31:0] target_pc = 32'h0;
   logic        br_commit = 1'b0;
   logic        br_real = 1'b0;
   logic [31:0] br_pc = 32'h0;

   inst_fetch dut (
      .clk                        (clk),
      .rst_n                      (rst_n),
      .rdy                        (rdy),
      .if_to_mc_enable            (if_to_mc_enable),
      .if_to_mc_pc                (if_to_mc_pc),
      .mc_to_if_done              (mc_to_if_done),
      .mc_to_if_inst              (mc_to_if_inst),
      .if_to_dc_valid             (if_to_dc_valid),
      .if_to_dc_inst              (if_to_dc_inst),
      .if_to_dc_pc                (if_to_dc_pc),
      .if_to_dc_pred_jump         (if_to_dc_pred_jump),
      .dc_to_if_stall             (dc_to_if_stall),
      .clr                        (clr),
      .rob_to_if_set_pc_enable    (set_pc_en),
      .rob_to_if_target_pc        (target_pc),
      .rob_to_if_br_commit_enable (br_commit),
      .rob_to_if_br_real_jump     (br_real),
      .rob_to_if_br_pc            (br_pc)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] pc;
      logic [31:0] inst;
      logic        pred;
   } ent_t;

   // Reference model
   ent_t        mq[$];
   logic [31:0] m_pc;
   logic [31:0] m_mcpc;
   bit          m_busy;
   bit          m_drain;
   int          bht[NBHT];
   ent_t        pop_log[$];

   // Memory responder
   logic [31:0] mem[logic [31:0]];
   logic [31:0] acc_log[$];
   bit          rand_mem = 1'b0;
   bit          srv = 1'b0;
   int          cnt = 0;
   int          lat = 2;
   logic [31:0] srv_addr = 32'h0;

   int n_tests = 0;
   int n_fail  = 0;
   int mark    = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   function automatic logic [31:0] enc_jal(input int imm);
      logic [20:0] im;
      im = imm[20:0];
      return {im[20], im[10:1], im[11], im[19:12], 5'd1, 7'h6F};
   endfunction

   function automatic logic [31:0] enc_beq(input int imm);
      logic [12:0] im;
      im = imm[12:0];
      return {im[12], im[10:5], 5'd2, 5'd1, 3'd0, im[4:1], im[11], 7'h63};
   endfunction

   function automatic logic [31:0] rand_word();
      int sel;
      int off;
      sel = $urandom_range(0, 9);
      off = 4 * ($urandom_range(0, 16) - 8);
      if (sel < 2)       return enc_jal(off);
      else if (sel < 5)  return enc_beq(off);
      else if (sel == 5) return 32'h00008067;
      else if (sel == 6) return $urandom();
      else               return 32'h00000013;
   endfunction

   function automatic logic [31:0] rand_addr();
      logic [31:0] base;
      base = ($urandom_range(0, 1) == 1) ? 32'h1000 : 32'h0;
      return base + 32'(4 * $urandom_range(0, 63));
   endfunction

   function automatic logic [31:0] fetch_word(input logic [31:0] a);
      if (!mem.exists(a)) mem[a] = rand_mem ? rand_word() : 32'h00000013;
      return mem[a];
   endfunction

   // ISA-level next-PC rule: JAL always taken, B-type by counter MSB, all else sequential.
   task automatic predict(input logic [31:0] pc, input logic [31:0] w,
                          output logic [31:0] npc, output logic p);
      int jimm;
      int bimm;
      jimm = int'($signed({w[31], w[19:12], w[20], w[30:21], 1'b0}));
      bimm = int'($signed({w[31], w[7], w[30:25], w[11:8], 1'b0}));
      npc = pc + 32'd4;
      p   = 1'b0;
      if (w[6:0] == 7'h6F) begin
         npc = pc + 32'(jimm);
         p   = 1'b1;
      end else if (w[6:0] == 7'h63 && PRED_EN && bht[pc[9:2]] >= 2) begin
         npc = pc + 32'(bimm);
         p   = 1'b1;
      end
   endtask

   task automatic model_reset();
      mq.delete();
      m_pc    = 32'h0;
      m_mcpc  = 32'h0;
      m_busy  = 1'b0;
      m_drain = 1'b0;
      for (int k = 0; k < NBHT; k++) bht[k] = 1;
   endtask

   task automatic model_step();
      int          pre;
      logic [31:0] npc;
      logic        p;
      ent_t        e;
      if (!rst_n || !rdy) return;
      pre = mq.size();
      predict(m_pc, mc_to_if_inst, npc, p);
      if (clr) begin
         mq.delete();
         if (set_pc_en) m_pc = target_pc;
         if (m_busy) begin
            m_busy  = 1'b0;
            m_drain = !mc_to_if_done;
         end else if (m_drain && mc_to_if_done) begin
            m_drain = 1'b0;
         end
      end else begin
         if (pre > 0 && !dc_to_if_stall) pop_log.push_back(mq.pop_front());
         if (m_drain) begin
            if (mc_to_if_done) m_drain = 1'b0;
         end else if (m_busy) begin
            if (mc_to_if_done) begin
               e.pc   = m_pc;
               e.inst = mc_to_if_inst;
               e.pred = p;
               mq.push_back(e);
               m_pc   = npc;
               m_busy = 1'b0;
            end
         end else if (pre < DEPTH) begin
            m_busy = 1'b1;
            m_mcpc = m_pc;
         end
      end
      if (PRED_EN && br_commit) begin
         if (br_real) begin
            if (bht[br_pc[9:2]] < 3) bht[br_pc[9:2]]++;
         end else begin
            if (bht[br_pc[9:2]] > 0) bht[br_pc[9:2]]--;
         end
      end
   endtask

   task automatic compare();
      chk("mc_enable", {31'b0, if_to_mc_enable}, {31'b0, m_busy});
      chk("mc_pc", if_to_mc_pc, m_mcpc);
      chk("dc_valid", {31'b0, if_to_dc_valid}, {31'b0, mq.size() > 0});
      if (mq.size() > 0 && if_to_dc_valid) begin
         chk("head_pc", if_to_dc_pc, mq[0].pc);
         chk("head_inst", if_to_dc_inst, mq[0].inst);
         chk("head_pred", {31'b0, if_to_dc_pred_jump}, {31'b0, mq[0].pred});
      end
   endtask

   task automatic mem_step();
      if (mc_to_if_done) begin
         mc_to_if_done = 1'b0;
         srv = 1'b0;
      end else begin
         if (!srv && if_to_mc_enable) begin
            srv      = 1'b1;
            cnt      = lat;
            srv_addr = if_to_mc_pc;
            acc_log.push_back(if_to_mc_pc);
         end
         if (srv) begin
            if (cnt == 0) begin
               mc_to_if_done = 1'b1;
               mc_to_if_inst = fetch_word(srv_addr);
            end else begin
               cnt--;
            end
         end
      end
   endtask

   task automatic tick();
      if (mc_to_if_done) rdy = 1'b1;
      @(posedge clk);
      model_step();
      @(negedge clk);
      compare();
      mem_step();
      clr       = 1'b0;
      set_pc_en = 1'b0;
      br_commit = 1'b0;
   endtask

   task automatic flush(input logic [31:0] t);
      clr       = 1'b1;
      set_pc_en = 1'b1;
      target_pc = t;
      tick();
      mark = acc_log.size();
   endtask

   task automatic commit_br(input logic [31:0] pc, input logic taken);
      br_commit = 1'b1;
      br_pc     = pc;
      br_real   = taken;
      tick();
   endtask

   task automatic wait_acc(input int n, input int bound);
      int k;
      k = 0;
      while (acc_log.size() < n && k < bound) begin
         tick();
         k++;
      end
      if (acc_log.size() < n) begin
         n_tests++;
         n_fail++;
         $display("FAIL wait_acc: got %0d requests, expected %0d", acc_log.size(), n);
      end
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached, expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [31:0] exp_tgt;
      logic [31:0] exp_pred;
      int          np;
      int          k;

      exp_tgt  = PRED_EN ? 32'h38 : 32'h44;
      exp_pred = PRED_EN ? 32'h1 : 32'h0;

      // Reset
      model_reset();
      repeat (3) @(negedge clk);
      chk("reset_mc_enable", {31'b0, if_to_mc_enable}, 32'h0);
      chk("reset_mc_pc", if_to_mc_pc, 32'h0);
      chk("reset_dc_valid", {31'b0, if_to_dc_valid}, 32'h0);
      rst_n = 1'b1;

      // Sequential fetch with 2-cycle memory latency
      dc_to_if_stall = 1'b1;
      lat = 2;
      wait_acc(3, 60);
      repeat (8) tick();
      chk("seq_req0", acc_log[0], 32'h0);
      chk("seq_req1", acc_log[1], 32'h4);
      chk("seq_req2", acc_log[2], 32'h8);
      chk("seq_head_pc", if_to_dc_pc, 32'h0);
      chk("seq_head_inst", if_to_dc_inst, 32'h00000013);
      dc_to_if_stall = 1'b0;
      repeat (4) tick();
      dc_to_if_stall = 1'b1;
      for (int i = 0; i < 3; i++) begin
         chk("seq_pop_pc", pop_log[i].pc, 32'(4 * i));
         chk("seq_pop_pred", {31'b0, pop_log[i].pred}, 32'h0);
      end

      // JAL prediction
      mem[32'h20] = 32'h0100006F;
      flush(32'h20);
      wait_acc(mark + 2, 40);
      repeat (2) tick();
      chk("jal_req", acc_log[mark], 32'h20);
      chk("jal_next_req", acc_log[mark + 1], 32'h30);
      chk("jal_head_pc", if_to_dc_pc, 32'h20);
      chk("jal_head_inst", if_to_dc_inst, 32'h0100006F);
      chk("jal_head_pred", {31'b0, if_to_dc_pred_jump}, 32'h1);

      // B-type prediction trained by commits
      mem[32'h40] = 32'hFE000CE3;
      flush(32'h40);
      wait_acc(mark + 2, 40);
      repeat (2) tick();
      chk("beq_cold_next", acc_log[mark + 1], 32'h44);
      chk("beq_cold_pred", {31'b0, if_to_dc_pred_jump}, 32'h0);
      commit_br(32'h40, 1'b1);
      commit_br(32'h40, 1'b1);
      flush(32'h40);
      wait_acc(mark + 2, 40);
      repeat (2) tick();
      chk("beq_trained_next", acc_log[mark + 1], exp_tgt);
      chk("beq_trained_pred", {31'b0, if_to_dc_pred_jump}, exp_pred);
      commit_br(32'h40, 1'b1);
      flush(32'h40);
      wait_acc(mark + 2, 40);
      repeat (2) tick();
      chk("beq_sat_next", acc_log[mark + 1], exp_tgt);
      chk("beq_sat_pred", {31'b0, if_to_dc_pred_jump}, exp_pred);

      // Queue full under stall, then a single pop
      flush(32'h200);
      wait_acc(mark + 16, 200);
      repeat (20) tick();
      chk("full_req_count", 32'(acc_log.size() - mark), 32'd16);
      chk("full_mc_enable", {31'b0, if_to_mc_enable}, 32'h0);
      chk("full_dc_valid", {31'b0, if_to_dc_valid}, 32'h1);
      np = pop_log.size();
      dc_to_if_stall = 1'b0;
      tick();
      dc_to_if_stall = 1'b1;
      wait_acc(mark + 17, 20);
      repeat (5) tick();
      chk("full_one_pop", 32'(pop_log.size() - np), 32'd1);
      chk("full_next_req", acc_log[mark + 16], 32'h240);
      chk("full_req_after", 32'(acc_log.size() - mark), 32'd17);

      // Flush while a request is outstanding
      dc_to_if_stall = 1'b0;
      k = 0;
      while (!if_to_mc_enable && k < 20) begin
         tick();
         k++;
      end
      chk("flush_wait_seen", {31'b0, if_to_mc_enable}, 32'h1);
      dc_to_if_stall = 1'b1;
      flush(32'h100);
      chk("flush_dc_valid", {31'b0, if_to_dc_valid}, 32'h0);
      chk("flush_mc_enable", {31'b0, if_to_mc_enable}, 32'h0);
      wait_acc(mark + 1, 30);
      repeat (6) tick();
      chk("flush_next_req", acc_log[mark], 32'h100);
      chk("flush_head_pc", if_to_dc_pc, 32'h100);

      // Global ready low: everything holds
      rdy = 1'b0;
      repeat (5) tick();
      rdy = 1'b1;

      // Randomised traffic
      rand_mem = 1'b1;
      for (int c = 0; c < 3000; c++) begin
         if (((c / 300) % 2) == 1) dc_to_if_stall = ($urandom_range(0, 3) != 0);
         else                      dc_to_if_stall = ($urandom_range(0, 3) == 0);
         rdy = ($urandom_range(0, 9) != 0);
         lat = $urandom_range(0, 3);
         if ($urandom_range(0, 39) == 0) begin
            clr       = 1'b1;
            set_pc_en = ($urandom_range(0, 3) != 0);
            target_pc = rand_addr();
         end
         if ($urandom_range(0, 3) == 0) begin
            br_commit = 1'b1;
            br_real   = ($urandom_range(0, 1) == 1);
            br_pc     = rand_addr();
         end
         tick();
      end
      rdy = 1'b1;
      repeat (10) tick();

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
